flow_rr_scheduler: RTL and testbench

Packet-granular read scheduler for the multichannel buffer.
- Tracks the number of complete packets pending per flow. The write side reports each accepted last beat.
- Issues one read grant at a time to the read engine, picking among eligible flows round-robin.
- Holds off further grants until the read engine reports that the granted packet's final beat has left.
- Sits beside buffer_top: fed by the write-side packet-commit strobe, driving the read-side flow select.

---
 rtl/buf_sched_pkg.sv | 18 +
 rtl/flow_rr_scheduler_rr_pick.sv | 35 +++
 rtl/flow_rr_scheduler.sv | 139 +++++++++++++
 tb/tb_flow_rr_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_sched_pkg.sv
// Shared types and default sizing for the packet-granular read scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package buf_sched_pkg;

  localparam int FLOWS_W_DEFAULT = 3;
  localparam int CNT_W_DEFAULT   = 6;
  localparam int NUM_FLOWS       = 1 << FLOWS_W_DEFAULT;

  typedef logic [FLOWS_W_DEFAULT-1:0] flow_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/flow_rr_scheduler_rr_pick.sv
// Picks one eligible flow: first set bit at or after ptr_i, wrapping (or lowest index with SCHED_STRICT_PRIO_EN).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
module rr_pick #(
  parameter int W = 3
) (
  input  logic [(1<<W)-1:0] elig_i,
  input  logic [W-1:0]      ptr_i,
  output logic              any_o,
  output logic [W-1:0]      idx_o
);

  localparam int N = 1 << W;

  logic [W-1:0] cand;

  // Scan from the farthest candidate back to the nearest so the last hit is the winner.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
`ifdef SCHED_STRICT_PRIO_EN
      cand = W'(i);
`else
      cand = ptr_i + W'(i);
`endif
      if (elig_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/flow_rr_scheduler.sv
// Per-flow pending-packet counters plus a one-grant-at-a-time read scheduler (optional macro SCHED_STRICT_PRIO_EN).
// Latency: commit at edge N -> grant_valid in cycle N+2; one idle cycle after rd_done before the next grant.
// Backpressure: grant_valid/grant_flow hold until grant_ready; no new grant until rd_done closes the packet.
module flow_rr_scheduler
  import buf_sched_pkg::*;
#(
  parameter int FLOWS_W = FLOWS_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  input  logic [FLOWS_W-1:0]      enq_flow,
  input  logic [(1<<FLOWS_W)-1:0] flow_en,
  output logic                    grant_valid,
  input  logic                    grant_ready,
  output logic [FLOWS_W-1:0]      grant_flow,
  input  logic                    rd_done,
  output logic [(1<<FLOWS_W)-1:0] pend_nonempty,
  output logic                    busy,
  output logic                    ovf_err,
  output logic                    proto_err
);

  localparam int NF = 1 << FLOWS_W;

  sched_state_t       state_q, state_d;
  logic [FLOWS_W-1:0] ptr_q, ptr_d;
  logic [FLOWS_W-1:0] gflow_q, gflow_d;
  logic [CNT_W-1:0]   cnt_q [NF];
  logic [CNT_W-1:0]   cnt_d [NF];
  logic               ovf_q, ovf_d;
  logic               proto_q, proto_d;

  logic [NF-1:0]      elig;
  logic               any_elig;
  logic [FLOWS_W-1:0] pick;
  logic               hs;

  assign hs = (state_q == GRANT) && grant_ready;

  // Eligibility and occupancy come from registered counts only; a commit this cycle is seen next cycle.
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      pend_nonempty[f] = (cnt_q[f] != '0);
      elig[f]          = pend_nonempty[f] && flow_en[f];
    end
  end

  rr_pick #(
    .W (FLOWS_W)
  ) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .any_o  (any_elig),
    .idx_o  (pick)
  );

  // Counter update: commit increments, handshake decrements, both together cancel; saturate and flag overflow.
  always_comb begin
    ovf_d = ovf_q;
    for (int f = 0; f < NF; f++) begin
      cnt_d[f] = cnt_q[f];
      if (enq_valid && (enq_flow == FLOWS_W'(f))) begin
        if (hs && (gflow_q == FLOWS_W'(f))) begin
          cnt_d[f] = cnt_q[f];
        end else if (cnt_q[f] == {CNT_W{1'b1}}) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[f] = cnt_q[f] + CNT_W'(1);
        end
      end else if (hs && (gflow_q == FLOWS_W'(f))) begin
        cnt_d[f] = cnt_q[f] - CNT_W'(1);
      end
    end
  end

  // Scheduler next-state: latch a pick in IDLE, hold it through GRANT, wait out the packet in BUSY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gflow_d = gflow_q;
    proto_d = proto_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          gflow_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d   = gflow_q + FLOWS_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (rd_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completion outside BUSY has no packet to close; it is dropped and remembered.
    if (rd_done && (state_q != BUSY)) begin
      proto_d = 1'b1;
    end
  end

  // State, pointer, latched grant, counters and sticky errors; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gflow_q <= '0;
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
      for (int f = 0; f < NF; f++) begin
        cnt_q[f] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gflow_q <= gflow_d;
      ovf_q   <= ovf_d;
      proto_q <= proto_d;
      for (int f = 0; f < NF; f++) begin
        cnt_q[f] <= cnt_d[f];
      end
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign busy        = (state_q == BUSY);
  assign grant_flow  = gflow_q;
  assign ovf_err     = ovf_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_flow_rr_scheduler.sv
// Self-checking bench for flow_rr_scheduler: scoreboard of expected grant order plus per-scenario checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_flow_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq_valid;
  logic [2:0] enq_flow;
  logic [7:0] flow_en;
  logic       grant_valid;
  logic       grant_ready;
  logic [2:0] grant_flow;
  logic       rd_done;
  logic [7:0] pend_nonempty;
  logic       busy;
  logic       ovf_err;
  logic       proto_err;

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  flow_rr_scheduler #(.FLOWS_W(3), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_flow      (enq_flow),
    .flow_en       (flow_en),
    .grant_valid   (grant_valid),
    .grant_ready   (grant_ready),
    .grant_flow    (grant_flow),
    .rd_done       (rd_done),
    .pend_nonempty (pend_nonempty),
    .busy          (busy),
    .ovf_err       (ovf_err),
    .proto_err     (proto_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; enq_valid = 1'b0; grant_ready = 1'b0; rd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic enq_one(input logic [2:0] f);
    enq_valid = 1'b1; enq_flow = f;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (grant_valid) ok = 1'b1;
      else tick();
    end
  endtask

  // Waits for a grant, records its flow, then handshakes and closes the packet.
  task automatic grant_cycle(output bit ok, output logic [2:0] fl);
    fl = 3'd0;
    wait_grant(ok);
    if (ok) begin
      fl = grant_flow;
      grant_ready = 1'b1; tick(); grant_ready = 1'b0;
      rd_done = 1'b1; tick(); rd_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst = 1'b1; enq_valid = 1'b0; enq_flow = 3'd0; flow_en = 8'hFF;
    grant_ready = 1'b0; rd_done = 1'b0;
    tick(); tick();
    obs = {grant_valid, busy, ovf_err, proto_err, pend_nonempty, grant_flow};
    compared++;
    if (obs !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0000", obs);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    enq_valid = 1'b1; enq_flow = 3'd5;
    tick();
    enq_valid = 1'b0;
    compared++;
    if ({grant_valid, pend_nonempty} !== {1'b0, 8'h20}) begin
      mismatched++;
      $display("FAIL single_n1: got gv=%b pend=%h want gv=0 pend=20", grant_valid, pend_nonempty);
    end
    tick();
    compared++;
    if ({grant_valid, grant_flow} !== {1'b1, 3'd5}) begin
      mismatched++;
      $display("FAIL single_n2: got gv=%b flow=%0d want gv=1 flow=5", grant_valid, grant_flow);
    end
    grant_ready = 1'b1; tick(); grant_ready = 1'b0;
    compared++;
    if ({busy, grant_valid, pend_nonempty} !== {1'b1, 1'b0, 8'h00}) begin
      mismatched++;
      $display("FAIL single_busy: got busy=%b gv=%b pend=%h want 1 0 00", busy, grant_valid, pend_nonempty);
    end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    repeat (3) tick();
    compared++;
    if ({busy, grant_valid, proto_err} !== 3'b000) begin
      mismatched++;
      $display("FAIL single_done: got busy=%b gv=%b perr=%b want 000", busy, grant_valid, proto_err);
    end
  endtask

  task automatic load_and_check_order(input string name);
    bit ok;
    logic [2:0] fl;
    logic [2:0] ex;
    flow_en = 8'h00;
    enq_one(3'd2); enq_one(3'd6); enq_one(3'd0);
    compared++;
    if (pend_nonempty !== 8'h45) begin
      mismatched++;
      $display("FAIL %s_pend: got %h want 45", name, pend_nonempty);
    end
    flow_en = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      grant_cycle(ok, fl);
      ex = 3'd0;
      if (exp_q.size() != 0) ex = exp_q.pop_front();
      compared++;
      if (!ok || fl !== ex) begin
        mismatched++;
        $display("FAIL %s_grant%0d: got ok=%b flow=%0d want flow=%0d", name, k, ok, fl, ex);
      end
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    logic [2:0] fl;
    reset_dut();
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd6);
    load_and_check_order("order_ptr0");
    // Move the pointer to 3 by granting flow 2 alone.
    reset_dut();
    flow_en = 8'hFF;
    enq_one(3'd2);
    grant_cycle(ok, fl);
    compared++;
    if (!ok || fl !== 3'd2) begin
      mismatched++;
      $display("FAIL order_setup: got ok=%b flow=%0d want flow=2", ok, fl);
    end
`ifdef SCHED_STRICT_PRIO_EN
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd6);
`else
    exp_q.push_back(3'd6); exp_q.push_back(3'd0); exp_q.push_back(3'd2);
`endif
    load_and_check_order("order_ptr3");
  endtask

  task automatic test_hold();
    bit ok;
    int bad;
    flow_en = 8'hFF;
    enq_one(3'd4);
    wait_grant(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL hold_wait: got no grant want grant");
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) flow_en = 8'hEF;
      if (grant_valid !== 1'b1 || grant_flow !== 3'd4) bad++;
      tick();
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    grant_ready = 1'b1; tick(); grant_ready = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_handshake: got busy=%b want 1", busy);
    end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    flow_en = 8'hFF;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [2:0] fl;
    logic [2:0] ex;
    flow_en = 8'hFF;
    enq_one(3'd1);
    wait_grant(ok);
    compared++;
    if (!ok || grant_flow !== 3'd1) begin
      mismatched++;
      $display("FAIL same_first: got ok=%b flow=%0d want flow=1", ok, grant_flow);
    end
    grant_ready = 1'b1; enq_valid = 1'b1; enq_flow = 3'd1;
    tick();
    grant_ready = 1'b0; enq_valid = 1'b0;
    compared++;
    if ({busy, pend_nonempty} !== {1'b1, 8'h02}) begin
      mismatched++;
      $display("FAIL same_count: got busy=%b pend=%h want 1 02", busy, pend_nonempty);
    end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    exp_q.push_back(3'd1);
    grant_cycle(ok, fl);
    ex = 3'd7;
    if (exp_q.size() != 0) ex = exp_q.pop_front();
    compared++;
    if (!ok || fl !== ex) begin
      mismatched++;
      $display("FAIL same_regrant: got ok=%b flow=%0d want flow=%0d", ok, fl, ex);
    end
    compared++;
    if (pend_nonempty !== 8'h00) begin
      mismatched++;
      $display("FAIL same_drained: got pend=%h want 00", pend_nonempty);
    end
  endtask

  task automatic test_errors();
    bit ok;
    logic [2:0] fl;
    int n;
    reset_dut();
    flow_en = 8'h00;
    enq_valid = 1'b1; enq_flow = 3'd3;
    repeat (63) tick();
    enq_valid = 1'b0;
    compared++;
    if ({ovf_err, pend_nonempty} !== {1'b0, 8'h08}) begin
      mismatched++;
      $display("FAIL ovf_at63: got ovf=%b pend=%h want 0 08", ovf_err, pend_nonempty);
    end
    enq_one(3'd3);
    compared++;
    if (ovf_err !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_set: got %b want 1", ovf_err);
    end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    compared++;
    if (proto_err !== 1'b1) begin
      mismatched++;
      $display("FAIL proto_set: got %b want 1", proto_err);
    end
    flow_en = 8'h08;
    n = 0;
    for (int i = 0; i < 70 && pend_nonempty != 8'h00; i++) begin
      grant_cycle(ok, fl);
      if (!ok) break;
      n++;
    end
    compared++;
    if (n != 63) begin
      mismatched++;
      $display("FAIL ovf_hold: got %0d grants want 63", n);
    end
    compared++;
    if ({ovf_err, proto_err} !== 2'b11) begin
      mismatched++;
      $display("FAIL err_sticky: got %b%b want 11", ovf_err, proto_err);
    end
    rst = 1'b1; tick();
    compared++;
    if ({ovf_err, proto_err} !== 2'b00) begin
      mismatched++;
      $display("FAIL err_clear: got %b%b want 00", ovf_err, proto_err);
    end
    rst = 1'b0; tick();
    flow_en = 8'hFF;
  endtask

  task automatic test_reset_busy();
    bit ok;
    logic [2:0] fl;
    logic [2:0] ex;
    logic [14:0] obs;
    int seen;
    reset_dut();
    flow_en = 8'hFF;
    enq_valid = 1'b1; enq_flow = 3'd2;
    tick(); tick();
    enq_valid = 1'b0;
    wait_grant(ok);
    grant_ready = 1'b1; tick(); grant_ready = 1'b0;
    compared++;
    if (!ok || {busy, pend_nonempty} !== {1'b1, 8'h04}) begin
      mismatched++;
      $display("FAIL rstbusy_pre: got ok=%b busy=%b pend=%h want 1 1 04", ok, busy, pend_nonempty);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    obs = {grant_valid, busy, ovf_err, proto_err, pend_nonempty, grant_flow};
    compared++;
    if (obs !== 15'd0) begin
      mismatched++;
      $display("FAIL rstbusy_outputs: got %h want 0000", obs);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (grant_valid !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL rstbusy_quiet: got %0d active cycles want 0", seen);
    end
    exp_q.push_back(3'd7);
    enq_one(3'd7);
    grant_cycle(ok, fl);
    ex = 3'd0;
    if (exp_q.size() != 0) ex = exp_q.pop_front();
    compared++;
    if (!ok || fl !== ex) begin
      mismatched++;
      $display("FAIL rstbusy_new: got ok=%b flow=%0d want flow=%0d", ok, fl, ex);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_hold();
    test_back_to_back();
    test_errors();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
